// File: rtl/lcd_driver.sv
// HD44780 16x2 character LCD sink: accepts 32-bit words of up to four ASCII bytes
// and replays them as timed address/data bus transactions, tracking a cursor per line.
module lcd_driver #(
  parameter int SETUP_CYC      = 4,
  parameter int EN_CYC         = 25,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int POWERUP_CYC    = 750000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        wr_line,
  input  logic [31:0] wr_data,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on
);

  typedef enum logic [2:0] {
    POWERUP,
    INIT,
    IDLE,
    NEXT,
    ADDR,
    CHAR
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_EN,
    PH_WAIT
  } phase_t;

  state_t      state;
  phase_t      phase;
  logic [31:0] cnt;
  logic [31:0] wait_len;
  logic [1:0]  init_idx;
  logic [31:0] word;
  logic        line;
  logic [1:0]  idx;
  logic [3:0]  cursor0;
  logic [3:0]  cursor1;

  logic [7:0]  sel_byte;
  logic [3:0]  cur_pos;
  logic [7:0]  addr_cmd;
  logic [7:0]  next_init_cmd;
  logic [31:0] next_init_wait;
  logic        bus_active;
  logic        step_done;

  assign lcd_rw = 1'b0;
  assign lcd_on = 1'b1;

  always_comb begin
    sel_byte = word[31:24];
    case (idx)
      2'd3:    sel_byte = word[31:24];
      2'd2:    sel_byte = word[23:16];
      2'd1:    sel_byte = word[15:8];
      default: sel_byte = word[7:0];
    endcase
  end

  assign cur_pos  = line ? cursor1 : cursor0;
  assign addr_cmd = {1'b1, line, 2'b00, cur_pos};

  // Successor of the command currently on the bus during INIT; 0x01 needs the long settle.
  always_comb begin
    next_init_cmd  = 8'h38;
    next_init_wait = 32'(CMD_WAIT_CYC);
    case (init_idx)
      2'd0: next_init_cmd = 8'h0C;
      2'd1: begin
        next_init_cmd  = 8'h01;
        next_init_wait = 32'(CLEAR_WAIT_CYC);
      end
      2'd2: next_init_cmd = 8'h06;
      default: next_init_cmd = 8'h38;
    endcase
  end

  assign bus_active = (state == INIT) || (state == ADDR) || (state == CHAR);
  assign step_done  = bus_active && (phase == PH_WAIT) && (cnt == 32'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= POWERUP;
      phase    <= PH_SETUP;
      cnt      <= 32'd0;
      wait_len <= 32'd0;
      init_idx <= 2'd0;
      word     <= 32'd0;
      line     <= 1'b0;
      idx      <= 2'd0;
      cursor0  <= 4'd0;
      cursor1  <= 4'd0;
      wr_ready <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      // Shared SETUP -> EN -> WAIT sequencer; a finished WAIT is handled per state below.
      if (bus_active && !step_done) begin
        if (cnt != 32'd0) begin
          cnt <= cnt - 32'd1;
        end else if (phase == PH_SETUP) begin
          phase  <= PH_EN;
          lcd_en <= 1'b1;
          cnt    <= 32'(EN_CYC - 1);
        end else begin
          phase  <= PH_WAIT;
          lcd_en <= 1'b0;
          cnt    <= wait_len - 32'd1;
        end
      end

      case (state)
        POWERUP: begin
          if (cnt == 32'(POWERUP_CYC - 1)) begin
            state    <= INIT;
            init_idx <= 2'd0;
            lcd_data <= 8'h38;
            lcd_rs   <= 1'b0;
            phase    <= PH_SETUP;
            cnt      <= 32'(SETUP_CYC - 1);
            wait_len <= 32'(CMD_WAIT_CYC);
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        INIT: begin
          if (step_done) begin
            if (init_idx == 2'd3) begin
              state    <= IDLE;
              wr_ready <= 1'b1;
            end else begin
              init_idx <= init_idx + 2'd1;
              lcd_data <= next_init_cmd;
              lcd_rs   <= 1'b0;
              phase    <= PH_SETUP;
              cnt      <= 32'(SETUP_CYC - 1);
              wait_len <= next_init_wait;
            end
          end
        end

        IDLE: begin
          if (wr_valid && wr_ready) begin
            word     <= wr_data;
            line     <= wr_line;
            idx      <= 2'd3;
            wr_ready <= 1'b0;
            state    <= NEXT;
          end
        end

        NEXT: begin
          if (sel_byte == 8'h00) begin
            if (idx == 2'd0) begin
              state    <= IDLE;
              wr_ready <= 1'b1;
            end else begin
              idx <= idx - 2'd1;
            end
          end else begin
            state    <= ADDR;
            lcd_data <= addr_cmd;
            lcd_rs   <= 1'b0;
            phase    <= PH_SETUP;
            cnt      <= 32'(SETUP_CYC - 1);
            wait_len <= 32'(CMD_WAIT_CYC);
          end
        end

        ADDR: begin
          if (step_done) begin
            state    <= CHAR;
            lcd_data <= sel_byte;
            lcd_rs   <= 1'b1;
            phase    <= PH_SETUP;
            cnt      <= 32'(SETUP_CYC - 1);
            wait_len <= 32'(CMD_WAIT_CYC);
          end
        end

        CHAR: begin
          if (step_done) begin
            if (line) cursor1 <= cursor1 + 4'd1;
            else      cursor0 <= cursor0 + 4'd1;
            if (idx == 2'd0) begin
              state    <= IDLE;
              wr_ready <= 1'b1;
            end else begin
              idx   <= idx - 2'd1;
              state <= NEXT;
            end
          end
        end

        default: state <= POWERUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_driver.sv
// Directed bench for lcd_driver: init sequence, table of character words with
// hand-computed bus traffic and busy time, plus busy-ignore and mid-op reset cases.
module tb_lcd_driver;
  localparam int S  = 1;
  localparam int E  = 2;
  localparam int CW = 3;
  localparam int CL = 5;
  localparam int PU = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        wr_line = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic        lcd_on;

  lcd_driver #(
    .SETUP_CYC(S), .EN_CYC(E), .CMD_WAIT_CYC(CW),
    .CLEAR_WAIT_CYC(CL), .POWERUP_CYC(PU)
  ) dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_line(wr_line), .wr_data(wr_data), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_on(lcd_on)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic        line;
    logic [31:0] data;
    int          exp_low;
    int          exp_ntx;
    logic [7:0]  exp_addr;
  } vec_t;

  vec_t       vt[12];
  logic [8:0] got_q[$];
  int         rise_q[$];
  logic [8:0] exp_q[$];
  logic [3:0] mc[2];
  logic       prev_en = 1'b0;
  logic [8:0] hold_bus = 9'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor: capture {rs,data} at each EN rise, check it held until EN fell.
  always @(negedge clock) begin
    if (reset) begin
      prev_en = 1'b0;
    end else begin
      if (!prev_en && lcd_en) begin
        got_q.push_back({lcd_rs, lcd_data});
        rise_q.push_back(cyc);
        hold_bus = {lcd_rs, lcd_data};
      end
      if (prev_en && !lcd_en) chk("bus_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, hold_bus});
      prev_en = lcd_en;
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!wr_ready && t < 1000) begin
      @(negedge clock);
      t++;
    end
    if (!wr_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_init();
    int edges = 0;
    got_q.delete();
    rise_q.delete();
    mc[0] = 4'd0;
    mc[1] = 4'd0;
    @(negedge clock);
    reset = 1'b0;
    while (!wr_ready && edges < 200) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
    end
    chk("init_ready_cycles", edges, 36);
    chk("init_pulses", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("init_cmd0", {23'd0, got_q[0]}, 32'h038);
      chk("init_cmd1", {23'd0, got_q[1]}, 32'h00C);
      chk("init_cmd2", {23'd0, got_q[2]}, 32'h001);
      chk("init_cmd3", {23'd0, got_q[3]}, 32'h006);
      chk("init_gap0", rise_q[1] - rise_q[0], 6);
      chk("init_gap1", rise_q[2] - rise_q[1], 6);
      chk("init_gap_clear", rise_q[3] - rise_q[2], 8);
    end
    $display("init: ready after %0d cycles, %0d pulses", edges, got_q.size());
  endtask

  task automatic run_vec(input vec_t v);
    int low = 0;
    logic [7:0] b;
    got_q.delete();
    exp_q.delete();
    for (int k = 3; k >= 0; k--) begin
      b = v.data[k*8 +: 8];
      if (b != 8'h00) begin
        exp_q.push_back({1'b0, 1'b1, v.line, 2'b00, mc[v.line]});
        exp_q.push_back({1'b1, b});
        mc[v.line] = mc[v.line] + 4'd1;
      end
    end
    wait_ready();
    @(negedge clock);
    wr_valid = 1'b1;
    wr_line  = v.line;
    wr_data  = v.data;
    @(posedge clock);
    @(negedge clock);
    wr_valid = 1'b0;
    while (!wr_ready && low < 2000) begin
      low++;
      @(negedge clock);
    end
    chk("ready_low", low, v.exp_low);
    chk("ntx", got_q.size(), v.exp_ntx);
    if (got_q.size() > 0) chk("first_addr", {24'd0, got_q[0][7:0]}, {24'd0, v.exp_addr});
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk("bus_tx", {23'd0, got_q[k]}, {23'd0, exp_q[k]});
    $display("xfer line=%0d data=%08h low=%0d ntx=%0d", v.line, v.data, low, got_q.size());
  endtask

  initial begin
    vt[0]  = '{1'b0, 32'h48690000, 28, 4, 8'h80};
    vt[1]  = '{1'b1, 32'h41414141, 52, 8, 8'hC0};
    vt[2]  = '{1'b1, 32'h41414141, 52, 8, 8'hC4};
    vt[3]  = '{1'b1, 32'h41414141, 52, 8, 8'hC8};
    vt[4]  = '{1'b1, 32'h41414141, 52, 8, 8'hCC};
    vt[5]  = '{1'b1, 32'h42000000, 16, 2, 8'hC0};
    vt[6]  = '{1'b0, 32'h00000000,  4, 0, 8'h00};
    vt[7]  = '{1'b0, 32'h00430044, 28, 4, 8'h82};
    vt[8]  = '{1'b0, 32'h01FF7E20, 52, 8, 8'h84};
    vt[9]  = '{1'b0, 32'h41424344, 52, 8, 8'h88};
    vt[10] = '{1'b0, 32'h45464748, 52, 8, 8'h8C};
    vt[11] = '{1'b0, 32'h49000000, 16, 2, 8'h80};

    @(negedge clock);
    chk("rst_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_en", {31'd0, lcd_en}, 32'd0);
    chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_data", {24'd0, lcd_data}, 32'd0);
    chk("rst_rw", {31'd0, lcd_rw}, 32'd0);
    chk("rst_on", {31'd0, lcd_on}, 32'd1);

    check_init();
    for (int i = 0; i < 12; i++) run_vec(vt[i]);

    // Request pulsed while busy must be ignored (cursor1 is 1 here).
    got_q.delete();
    wait_ready();
    @(negedge clock);
    wr_valid = 1'b1; wr_line = 1'b1; wr_data = 32'h43000000;
    @(posedge clock);
    @(negedge clock);
    wr_valid = 1'b0;
    repeat (3) @(negedge clock);
    wr_valid = 1'b1; wr_data = 32'h5A000000;
    @(negedge clock);
    wr_valid = 1'b0;
    wait_ready();
    repeat (3) @(negedge clock);
    chk("busy_ntx", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("busy_addr", {23'd0, got_q[0]}, 32'h0C1);
      chk("busy_char", {23'd0, got_q[1]}, 32'h143);
    end
    $display("xfer busy-ignore ntx=%0d", got_q.size());

    // Request held through a busy period is taken on the first ready cycle.
    got_q.delete();
    begin
      int low = 0;
      @(negedge clock);
      wr_valid = 1'b1; wr_line = 1'b1; wr_data = 32'h44000000;
      @(posedge clock);
      @(negedge clock);
      wr_data = 32'h5A000000;
      while (!wr_ready && low < 2000) begin
        low++;
        @(negedge clock);
      end
      chk("held_low", low, 16);
      @(negedge clock);
      chk("held_accept", {31'd0, wr_ready}, 32'd0);
      wr_valid = 1'b0;
      wait_ready();
    end
    chk("held_ntx", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("held_tx0", {23'd0, got_q[0]}, 32'h0C2);
      chk("held_tx1", {23'd0, got_q[1]}, 32'h144);
      chk("held_tx2", {23'd0, got_q[2]}, 32'h0C3);
      chk("held_tx3", {23'd0, got_q[3]}, 32'h15A);
    end
    $display("xfer held-request ntx=%0d", got_q.size());

    // Reset during the EN phase of a data write.
    got_q.delete();
    rise_q.delete();
    begin
      int t = 0;
      @(negedge clock);
      wr_valid = 1'b1; wr_line = 1'b0; wr_data = 32'h51000000;
      @(posedge clock);
      @(negedge clock);
      wr_valid = 1'b0;
      #1;
      while (rise_q.size() < 2 && t < 200) begin
        @(negedge clock);
        #1;
        t++;
      end
      chk("midop_char_en", {31'd0, lcd_en}, 32'd1);
      chk("midop_char_rs", {31'd0, lcd_rs}, 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("midop_en", {31'd0, lcd_en}, 32'd0);
      chk("midop_ready", {31'd0, wr_ready}, 32'd0);
      chk("midop_data", {24'd0, lcd_data}, 32'd0);
      $display("xfer mid-op reset en=%0d ready=%0d", lcd_en, wr_ready);
    end
    repeat (3) @(negedge clock);
    check_init();
    run_vec('{1'b0, 32'h52000000, 16, 2, 8'h80});
    run_vec('{1'b1, 32'h53000000, 16, 2, 8'hC0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
